// File: rtl/mdu_unit_pkg.sv
// ---------------------------------------------------------------------------
// mdu_unit_pkg
// Shared definitions for the multiply/divide unit: the E-stage operation
// encoding, the multiply and divide latencies, the width of the latency
// counter and small decode helpers used by mdu_unit and mdu_calc.
//
// Configuration macro: MDU_MADD_EN
//   defined   -> MADD/MADDU/MSUB/MSUBU (codes 7-10) are compute operations
//   undefined -> codes 7-10 decode as no operation
// ---------------------------------------------------------------------------
package mdu_unit_pkg;

   localparam int CNT_W       = 4;
   localparam int MULT_CYCLES = 5;
   localparam int DIV_CYCLES  = 10;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MADD  = 4'd7,
      OP_MADDU = 4'd8,
      OP_MSUB  = 4'd9,
      OP_MSUBU = 4'd10
   } mdu_op_e;

   // Ops that use the multiplier and therefore take MULT_CYCLES.
   // The accumulate forms only belong to this family when they are built in.
   function automatic logic isMultOp(input logic [3:0] op);
      logic hit;
      hit = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
      hit = hit || (op == OP_MADD) || (op == OP_MADDU) ||
            (op == OP_MSUB) || (op == OP_MSUBU);
`endif
      return hit;
   endfunction

   // Ops that use the divider and therefore take DIV_CYCLES.
   function automatic logic isDivOp(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// ---------------------------------------------------------------------------
// mdu_calc
// Purely combinational result generator for the multiply/divide unit. It
// works on the operands latched when an operation was accepted, so the
// result is stable for the whole time the operation is in flight.
//
// Ports:
//   op_i      latched operation code
//   a_i, b_i  latched rs / rt operands
//   hi_i      HI value latched at acceptance (accumulate base)
//   lo_i      LO value latched at acceptance (accumulate base)
//   result_o  64-bit {HI,LO} result
//   we_o      result is to be written (low for divide by zero, non-compute)
//
// Configuration macro: MDU_MADD_EN enables the multiply-accumulate datapath.
// ---------------------------------------------------------------------------
module mdu_calc
   import mdu_unit_pkg::*;
(
   input  logic [3:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   output logic [63:0] result_o,
   output logic        we_o
);

   logic [63:0] prodSigned;
   logic [63:0] prodUnsigned;
   logic [31:0] aMag;
   logic [31:0] bMag;
   logic [31:0] bMagSafe;
   logic [31:0] quoMag;
   logic [31:0] remMag;
   logic [31:0] quoSigned;
   logic [31:0] remSigned;
   logic [31:0] bUnsSafe;
   logic [31:0] quoUns;
   logic [31:0] remUns;

   // Only the low 64 bits of the product are kept, so multiplying the
   // sign-extended operands as plain vectors gives the signed product.
   assign prodSigned   = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
   assign prodUnsigned = {32'd0, a_i} * {32'd0, b_i};

   // Signed division is done on magnitudes so that no corner case (such as
   // the most negative value divided by -1) relies on signed-divide
   // behaviour; the quotient sign follows the operand signs and the
   // remainder takes the dividend's sign, i.e. truncation toward zero.
   assign aMag      = a_i[31] ? (32'd0 - a_i) : a_i;
   assign bMag      = b_i[31] ? (32'd0 - b_i) : b_i;
   assign bMagSafe  = (b_i == 32'd0) ? 32'd1 : bMag;
   assign quoMag    = aMag / bMagSafe;
   assign remMag    = aMag % bMagSafe;
   assign quoSigned = (a_i[31] ^ b_i[31]) ? (32'd0 - quoMag) : quoMag;
   assign remSigned = a_i[31] ? (32'd0 - remMag) : remMag;

   assign bUnsSafe  = (b_i == 32'd0) ? 32'd1 : b_i;
   assign quoUns    = a_i / bUnsSafe;
   assign remUns    = a_i % bUnsSafe;

`ifndef MDU_MADD_EN
   logic unusedAcc;
   assign unusedAcc = ^{hi_i, lo_i};
`endif

   // Select the result for the latched op. A zero divisor leaves HI/LO
   // untouched by simply not asserting the write enable.
   always_comb begin
      result_o = 64'd0;
      we_o     = 1'b0;
      case (op_i)
         OP_MULT: begin
            result_o = prodSigned;
            we_o     = 1'b1;
         end
         OP_MULTU: begin
            result_o = prodUnsigned;
            we_o     = 1'b1;
         end
         OP_DIV: begin
            result_o = {remSigned, quoSigned};
            we_o     = (b_i != 32'd0);
         end
         OP_DIVU: begin
            result_o = {remUns, quoUns};
            we_o     = (b_i != 32'd0);
         end
`ifdef MDU_MADD_EN
         OP_MADD: begin
            result_o = {hi_i, lo_i} + prodSigned;
            we_o     = 1'b1;
         end
         OP_MADDU: begin
            result_o = {hi_i, lo_i} + prodUnsigned;
            we_o     = 1'b1;
         end
         OP_MSUB: begin
            result_o = {hi_i, lo_i} - prodSigned;
            we_o     = 1'b1;
         end
         OP_MSUBU: begin
            result_o = {hi_i, lo_i} - prodUnsigned;
            we_o     = 1'b1;
         end
`endif
         default: begin
            result_o = 64'd0;
            we_o     = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mdu_unit.sv
// ---------------------------------------------------------------------------
// mdu_unit
// E-stage multiply/divide unit with HI/LO registers. A compute op is accepted
// when the unit is idle and no exception is being taken; it then runs for a
// fixed latency while busy stalls the pipeline, and HI/LO are written on the
// final counting edge. MTHI/MTLO write HI/LO directly when idle.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, cancels any in-flight op
//   op     E-stage MDU operation code (mdu_unit_pkg encoding)
//   A, B   forwarded rs / rt operands
//   req    exception/interrupt this cycle; suppresses the incoming op
//   busy   hazard stall request
//   HI, LO architectural HI/LO register values
//
// Configuration macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
// ---------------------------------------------------------------------------
module mdu_unit
   import mdu_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        req,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   logic [CNT_W-1:0] cntQ;
   logic [CNT_W-1:0] cntD;
   logic [3:0]       opQ;
   logic [31:0]      aQ;
   logic [31:0]      bQ;
   logic [31:0]      hiBaseQ;
   logic [31:0]      loBaseQ;
   logic [31:0]      hiQ;
   logic [31:0]      hiD;
   logic [31:0]      loQ;
   logic [31:0]      loD;
   logic             idle;
   logic             accept;
   logic [63:0]      calcResult;
   logic             calcWe;

   mdu_calc uCalc (
      .op_i     (opQ),
      .a_i      (aQ),
      .b_i      (bQ),
      .hi_i     (hiBaseQ),
      .lo_i     (loBaseQ),
      .result_o (calcResult),
      .we_o     (calcWe)
   );

   // Acceptance, busy and counter next state. Busy rises combinationally in
   // the accepting cycle so the op behind this one stalls immediately.
   // HI/LO are written on the 1->0 counter edge; otherwise an idle,
   // unsuppressed MTHI/MTLO writes them directly.
   always_comb begin
      idle   = (cntQ == '0);
      accept = (isMultOp(op) || isDivOp(op)) && !req && idle;
      busy   = accept || !idle;

      cntD = cntQ;
      if (accept) begin
         cntD = isDivOp(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (!idle) begin
         cntD = cntQ - CNT_W'(1);
      end

      hiD = hiQ;
      loD = loQ;
      if (cntQ == CNT_W'(1)) begin
         if (calcWe) begin
            hiD = calcResult[63:32];
            loD = calcResult[31:0];
         end
      end else if (idle && !req) begin
         if (op == OP_MTHI) begin
            hiD = A;
         end
         if (op == OP_MTLO) begin
            loD = A;
         end
      end
   end

   // Counter and HI/LO registers; reset clears them at any time, abandoning
   // whatever operation was in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cntQ <= '0;
         hiQ  <= 32'd0;
         loQ  <= 32'd0;
      end else begin
         cntQ <= cntD;
         hiQ  <= hiD;
         loQ  <= loD;
      end
   end

   // Operand capture on acceptance. HI/LO are captured too so an
   // accumulate op works from the values present when it was issued.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         opQ     <= OP_NONE;
         aQ      <= 32'd0;
         bQ      <= 32'd0;
         hiBaseQ <= 32'd0;
         loBaseQ <= 32'd0;
      end else if (accept) begin
         opQ     <= op;
         aQ      <= A;
         bQ      <= B;
         hiBaseQ <= hiQ;
         loBaseQ <= loQ;
      end
   end

   assign HI = hiQ;
   assign LO = loQ;

endmodule

// File: tb/tb_mdu_unit.sv
// ---------------------------------------------------------------------------
// tb_mdu_unit
// Self-checking bench for mdu_unit. Stimulus pushes the expected completion
// (busy length and HI/LO) into a scoreboard queue; a monitor pops an entry
// whenever busy falls and compares. Zero-latency effects are checked inline.
// ---------------------------------------------------------------------------
module tb_mdu_unit;
   import mdu_unit_pkg::*;

   typedef struct {
      string       name;
      int          busyLen;
      logic [31:0] hi;
      logic [31:0] lo;
   } sbEntry_t;

   logic        clk;
   logic        reset;
   logic [3:0]  opIn;
   logic [31:0] aIn;
   logic [31:0] bIn;
   logic        reqIn;
   logic        busy;
   logic [31:0] hiOut;
   logic [31:0] loOut;

   int       testsRun;
   int       testsFailed;
   sbEntry_t sbQ[$];
   int       busyRun;
   logic     prevBusy;

   mdu_unit dut (
      .clk   (clk),
      .reset (reset),
      .op    (opIn),
      .A     (aIn),
      .B     (bIn),
      .req   (reqIn),
      .busy  (busy),
      .HI    (hiOut),
      .LO    (loOut)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something never returns.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Holds the op for exactly one cycle and checks busy combinationally
   // within that cycle. Returns #1 after the accepting edge.
   task automatic applyStimulus(input string name, input logic [3:0] opc,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic rq, input logic expBusy);
      @(posedge clk);
      #1;
      opIn  = opc;
      aIn   = a;
      bIn   = b;
      reqIn = rq;
      #3;
      checkOutput({name, "_busyT"}, {31'd0, busy}, {31'd0, expBusy});
      @(posedge clk);
      #1;
      opIn  = OP_NONE;
      reqIn = 1'b0;
   endtask

   task automatic pushExpect(input string name, input int len,
                             input logic [31:0] hi, input logic [31:0] lo);
      sbEntry_t e;
      e.name    = name;
      e.busyLen = len;
      e.hi      = hi;
      e.lo      = lo;
      sbQ.push_back(e);
   endtask

   task automatic waitIdle(input string name);
      bit done;
      done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (!busy) done = 1;
      end
      if (!done) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL %s_timeout: busy still 1 after 40 cycles, expected 0", name);
      end
   endtask

   // Monitor: counts busy cycles and, on each busy fall, checks the
   // completion against the oldest scoreboard entry.
   always @(negedge clk) begin
      if (reset) begin
         busyRun  = 0;
         prevBusy = 1'b0;
      end else begin
         if (busy) begin
            busyRun++;
         end else if (prevBusy) begin
            if (sbQ.size() == 0) begin
               testsRun++;
               testsFailed++;
               $display("[TB] FAIL unexpected_completion: got busy fall, expected none");
            end else begin
               sbEntry_t e;
               e = sbQ.pop_front();
               checkOutput({e.name, "_busyLen"}, 32'(busyRun), 32'(e.busyLen));
               checkOutput({e.name, "_HI"}, hiOut, e.hi);
               checkOutput({e.name, "_LO"}, loOut, e.lo);
            end
            busyRun = 0;
         end
         prevBusy = busy;
      end
   end

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      busyRun     = 0;
      prevBusy    = 1'b0;
      reset       = 1'b1;
      opIn        = OP_NONE;
      aIn         = 32'd0;
      bIn         = 32'd0;
      reqIn       = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_HI", hiOut, 32'd0);
      checkOutput("reset_LO", loOut, 32'd0);
      reset = 1'b0;

      // Multiply: signed and unsigned of the same bit patterns.
      pushExpect("mult", 6, 32'hFFFFFFFF, 32'hFFFFFFFE);
      applyStimulus("mult", OP_MULT, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b1);
      waitIdle("mult");
      pushExpect("multu", 6, 32'h00000001, 32'hFFFFFFFE);
      applyStimulus("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b1);
      waitIdle("multu");

      // Divide: -7/2 truncates toward zero, remainder takes dividend sign.
      pushExpect("div", 11, 32'hFFFFFFFF, 32'hFFFFFFFD);
      applyStimulus("div", OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1);
      waitIdle("div");
      pushExpect("divu", 11, 32'd1, 32'd3);
      applyStimulus("divu", OP_DIVU, 32'd7, 32'd2, 1'b0, 1'b1);
      waitIdle("divu");

      // Direct moves, then divide by zero leaves them in place.
      applyStimulus("mthi", OP_MTHI, 32'h11, 32'd0, 1'b0, 1'b0);
      checkOutput("mthi_HI", hiOut, 32'h11);
      applyStimulus("mtlo", OP_MTLO, 32'h22, 32'd0, 1'b0, 1'b0);
      checkOutput("mtlo_LO", loOut, 32'h22);
      pushExpect("div0", 11, 32'h11, 32'h22);
      applyStimulus("div0", OP_DIV, 32'd5, 32'd0, 1'b0, 1'b1);
      waitIdle("div0");

      // Suppressed ops and an undecoded code have no effect.
      applyStimulus("multReq", OP_MULT, 32'd3, 32'd4, 1'b1, 1'b0);
      waitIdle("multReq");
      checkOutput("multReq_HI", hiOut, 32'h11);
      checkOutput("multReq_LO", loOut, 32'h22);
      applyStimulus("opF", 4'hF, 32'd3, 32'd4, 1'b0, 1'b0);
      checkOutput("opF_HI", hiOut, 32'h11);
      applyStimulus("mthiReq", OP_MTHI, 32'hABCD, 32'd0, 1'b1, 1'b0);
      checkOutput("mthiReq_HI", hiOut, 32'h11);
      applyStimulus("mthi2", OP_MTHI, 32'hABCD, 32'd0, 1'b0, 1'b0);
      checkOutput("mthi2_HI", hiOut, 32'hABCD);

      // MTLO issued while a multiply is in flight is dropped.
      pushExpect("multBusy", 6, 32'd0, 32'd12);
      applyStimulus("multBusy", OP_MULT, 32'd3, 32'd4, 1'b0, 1'b1);
      applyStimulus("mtloBusy", OP_MTLO, 32'h55, 32'd0, 1'b0, 1'b1);
      waitIdle("multBusy");
      checkOutput("mtloBusy_LO", loOut, 32'd12);

      // Reset in the middle of a divide, then a multiply right after.
      applyStimulus("divRst", OP_DIV, 32'd100, 32'd7, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("midReset_busy", {31'd0, busy}, 32'd0);
      checkOutput("midReset_HI", hiOut, 32'd0);
      checkOutput("midReset_LO", loOut, 32'd0);
      @(posedge clk);
      #1;
      pushExpect("postRst", 6, 32'd0, 32'd42);
      reset = 1'b0;
      opIn  = OP_MULT;
      aIn   = 32'd6;
      bIn   = 32'd7;
      #3;
      checkOutput("postRst_busyT", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
      opIn = OP_NONE;
      waitIdle("postRst");

      // Multiply-accumulate family.
      applyStimulus("maddHi", OP_MTHI, 32'd0, 32'd0, 1'b0, 1'b0);
      applyStimulus("maddLo", OP_MTLO, 32'd5, 32'd0, 1'b0, 1'b0);
`ifdef MDU_MADD_EN
      pushExpect("madd", 6, 32'd0, 32'd17);
      applyStimulus("madd", OP_MADD, 32'd3, 32'd4, 1'b0, 1'b1);
      waitIdle("madd");
`else
      applyStimulus("madd", OP_MADD, 32'd3, 32'd4, 1'b0, 1'b0);
      checkOutput("madd_HI", hiOut, 32'd0);
      checkOutput("madd_LO", loOut, 32'd5);
`endif
      applyStimulus("msubuLo", OP_MTLO, 32'd0, 32'd0, 1'b0, 1'b0);
`ifdef MDU_MADD_EN
      pushExpect("msubu", 6, 32'hFFFFFFFF, 32'hFFFFFFFF);
      applyStimulus("msubu", OP_MSUBU, 32'd1, 32'd1, 1'b0, 1'b1);
      waitIdle("msubu");
`else
      applyStimulus("msubu", OP_MSUBU, 32'd1, 32'd1, 1'b0, 1'b0);
      checkOutput("msubu_HI", hiOut, 32'd0);
      checkOutput("msubu_LO", loOut, 32'd0);
`endif

      repeat (2) @(posedge clk);
      checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- op  in  4  E-stage MDU operation code (package encoding)
- A  in  32  rs operand, already forwarded
- B  in  32  rt operand, already forwarded
- req  in  1  exception/interrupt taken this cycle; suppresses all side effects of op
- busy  out  1  to hazard control (E_MDU_busy)
- HI  out  32  HI register value
- LO  out  32  LO register value
REQ-002 SHALL have no parameters; latencies come from package constants (name, default, meaning): MULT_CYCLES, 5, multiply latency; DIV_CYCLES, 10, divide latency.

Function
REQ-003 SHALL decode op: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10; other codes act as NONE.
REQ-004 SHALL accept a compute op (MULT..DIVU, MADD..MSUBU) at cycle T only when req=0 and the internal counter is 0; an accepted op latches A, B, op and current HI/LO at the T edge.
REQ-005 SHALL load the counter with MULT_CYCLES (mult family) or DIV_CYCLES (div family) at the T edge and decrement it by 1 each later edge.
REQ-006 SHALL drive busy = (compute op present, req=0, counter=0) OR (counter!=0); busy is high combinationally in cycle T and stays high through T+5 (mult) or T+10 (div).
REQ-007 SHALL write HI/LO on the edge where the counter goes 1->0; new values visible from T+6 (mult) / T+11 (div).
REQ-008 SHALL compute: MULT signed 64-bit product, MULTU unsigned, {HI,LO}=product; DIV LO=signed quotient truncated toward zero, HI=remainder with dividend's sign; DIVU unsigned.
REQ-009 SHALL leave HI/LO unchanged when a DIV/DIVU divisor is 0; busy timing is unchanged.
REQ-010 SHALL write HI=A (MTHI) or LO=A (MTLO) at the T edge with zero latency, only when req=0 and counter=0; busy stays low.
REQ-011 SHALL ignore any op (compute or MTHI/MTLO) arriving while counter!=0; the in-flight op completes unaffected.
REQ-012 SHALL ignore op entirely when req=1 in the same cycle; no counter load, no HI/LO write, busy only reflects counter.
REQ-013 SHALL NOT cancel an in-flight operation on req; only reset cancels it.

Reset
REQ-014 SHALL on reset asserted (any time, incl. mid-operation) immediately force counter=0, busy=0, HI=0, LO=0, latched operands=0.
REQ-015 SHALL accept a new op on the first edge after reset deasserts.

Configuration
REQ-016 SHALL, with MDU_MADD_EN defined, implement MADD/MADDU/MSUB/MSUBU with MULT_CYCLES latency: {HI,LO} = {HI,LO} latched at T +/- A*B (signed for MADD/MSUB, unsigned for MADDU/MSUBU), 64-bit wraparound.
REQ-017 SHALL, without MDU_MADD_EN, treat codes 7-10 as NONE (no busy, no writes) and omit the accumulate datapath.

Structure
REQ-018 SHALL place op encodings, MULT_CYCLES, DIV_CYCLES and the counter width (4 bits) in the shared macros package.
REQ-019 SHALL contain one combinational sub-module mdu_calc (latched op, A, B, HI, LO -> 64-bit result + write-enable); counter, busy and HI/LO registers remain in mdu_unit.

Verification
REQ-020 MULT A=0xFFFFFFFF B=2 at T -> busy high T..T+5; from T+6 HI=0xFFFFFFFF LO=0xFFFFFFFE; MULTU same operands -> HI=0x00000001 LO=0xFFFFFFFE.
REQ-021 DIV A=0xFFFFFFF9(-7) B=2 -> busy T..T+10; from T+11 LO=0xFFFFFFFD HI=0xFFFFFFFF; DIVU A=7 B=2 -> LO=3 HI=1.
REQ-022 HI=0x11 LO=0x22, DIV A=5 B=0 -> busy 11 cycles, HI=0x11 LO=0x22 unchanged.
REQ-023 MULT with req=1 -> busy low in T, HI/LO unchanged; MTHI A=0xABCD with req=1 -> HI unchanged; with req=0 -> HI=0xABCD at T+1; MTLO during busy -> ignored.
REQ-024 DIV started at T, reset pulsed at T+4 -> busy=0 and HI=LO=0 immediately; MULT at first post-reset cycle completes normally.
REQ-025 MDU_MADD_EN defined: HI=0 LO=5, MADD A=3 B=4 -> LO=17 HI=0 at T+6; MSUBU HI=0 LO=0 A=1 B=1 -> HI=LO=0xFFFFFFFF; macro undefined: same ops -> busy low, HI/LO unchanged.
